frame_mem_arbiter: RTL and testbench

//  Two-port Avalon-MM arbiter in front of the DDR3 controller. Shares one memory master

---
 rtl/frame_mem_arbiter_if.sv | 28 ++
 rtl/frame_mem_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_frame_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_mem_arbiter_if.sv
// Avalon-MM style bus bundle shared by the two requesting ports and the memory side.
//   master modport: drives address/read/write/burstcount/writedata,
//                   receives waitrequest/readdata/readdatavalid.
//   slave modport : the mirror image.
interface frame_mem_arbiter_if #(
  parameter int unsigned ADDR_W  = 26,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BURST_W = 4
);
  logic [ADDR_W-1:0]  address;
  logic               read;
  logic               write;
  logic [BURST_W-1:0] burstcount;
  logic [DATA_W-1:0]  writedata;
  logic               waitrequest;
  logic [DATA_W-1:0]  readdata;
  logic               readdatavalid;

  modport master (
    output address, read, write, burstcount, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, burstcount, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/frame_mem_arbiter.sv
// Two-port arbiter sharing one Avalon-MM memory master (DDR3 controller).
// Port 0 (scanout line fetch) has priority; port 1 carries draw/CPU reads and
// burst writes. Read bursts are tagged in issue order so returning beats are
// routed back to the port that asked for them.
//
// Ports:
//   clk_clk      single clock
//   reset_reset  synchronous, active-high reset
//   s0, s1       requesting ports (slave side of the bus bundle)
//   avm          memory master (master side of the bus bundle)
//   err_orphan   sticky: read beat returned with no read outstanding
//
// Build option: define ARB_STARVE_GUARD_EN to force a port-1 grant after
// STARVE_LIM consecutive port-0 grants taken while port 1 was waiting.
// Without it port 0 has strict priority.
module frame_mem_arbiter #(
  parameter int unsigned ADDR_W     = 26,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BURST_W    = 4,
  parameter int unsigned MAX_PEND   = 4
`ifdef ARB_STARVE_GUARD_EN
  , parameter int unsigned STARVE_LIM = 8
`endif
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  frame_mem_arbiter_if.slave  s0,
  frame_mem_arbiter_if.slave  s1,
  frame_mem_arbiter_if.master avm,
  output logic                err_orphan
);

  localparam int unsigned PTR_W = $clog2(MAX_PEND);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  typedef struct packed {
    logic               port;
    logic [BURST_W-1:0] rem;
  } tag_t;

  state_t             state;
  logic [BURST_W-1:0] beat_cnt;
  tag_t               tag_mem [MAX_PEND];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               req0, req1, force1, pick1;
  logic               granted, sel1, in_burst;
  logic               c_read, c_write;
  logic [ADDR_W-1:0]  c_addr;
  logic [BURST_W-1:0] c_bc;
  logic [DATA_W-1:0]  c_wdata;
  logic               g_read, g_write, blocked;
  logic [BURST_W-1:0] g_bc;
  logic               fifo_full, fifo_empty;
  logic               rd_acc, wr_acc, push, pop, beat;
  tag_t               head;

  assign req0       = s0.read | s0.write;
  assign req1       = s1.read | s1.write;
  assign granted    = (state != IDLE);
  assign sel1       = (state == G1);
  assign in_burst   = (beat_cnt != '0);
  assign fifo_full  = (count == CNT_W'(MAX_PEND));
  assign fifo_empty = (count == '0);

  // Starvation guard: counts port-0 grants taken while port 1 is waiting.
`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned SC_W = $clog2(STARVE_LIM + 1);
  logic [SC_W-1:0] starve_cnt;

  assign force1 = req1 & (starve_cnt == SC_W'(STARVE_LIM));

  always_ff @(posedge clk_clk) begin : starve_p
    if (reset_reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (pick1) begin
        starve_cnt <= '0;
      end else if (req0 && req1 && (starve_cnt != SC_W'(STARVE_LIM))) begin
        starve_cnt <= starve_cnt + SC_W'(1);
      end
    end
  end
`else
  assign force1 = 1'b0;
`endif

  assign pick1 = req1 & (~req0 | force1);

  // Command mux from the granted port.
  always_comb begin : cmd_mux
    if (sel1) begin
      c_read  = s1.read;
      c_write = s1.write;
      c_addr  = s1.address;
      c_bc    = s1.burstcount;
      c_wdata = s1.writedata;
    end else begin
      c_read  = s0.read;
      c_write = s0.write;
      c_addr  = s0.address;
      c_bc    = s0.burstcount;
      c_wdata = s0.writedata;
    end
  end

  // Read wins over write; once a write burst is under way only writes pass.
  assign g_read  = granted & c_read & ~in_burst;
  assign g_write = granted & c_write & ~g_read;
  assign g_bc    = (c_bc == '0) ? BURST_W'(1) : c_bc;
  assign blocked = g_read & fifo_full;

  assign avm.address    = c_addr;
  assign avm.read       = g_read & ~fifo_full;
  assign avm.write      = g_write;
  assign avm.burstcount = g_bc;
  assign avm.writedata  = c_wdata;

  assign s0.waitrequest = (state == G0) ? (avm.waitrequest | blocked) : 1'b1;
  assign s1.waitrequest = (state == G1) ? (avm.waitrequest | blocked) : 1'b1;

  assign rd_acc = avm.read & ~avm.waitrequest;
  assign wr_acc = avm.write & ~avm.waitrequest;
  assign push   = rd_acc;

  // Return path: the oldest outstanding burst owns every returning beat.
  assign head = tag_mem[rd_ptr];
  assign beat = avm.readdatavalid & ~fifo_empty;
  assign pop  = beat & (head.rem <= BURST_W'(1));

  assign s0.readdata      = avm.readdata;
  assign s1.readdata      = avm.readdata;
  assign s0.readdatavalid = beat & ~head.port;
  assign s1.readdatavalid = beat & head.port;

  // Grant FSM and write-burst beat counter.
  always_ff @(posedge clk_clk) begin : fsm_p
    if (reset_reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state <= pick1 ? G1 : G0;
          end
        end
        G0, G1: begin
          if (wr_acc) begin
            if (in_burst) begin
              beat_cnt <= beat_cnt - BURST_W'(1);
              if (beat_cnt == BURST_W'(1)) begin
                state <= IDLE;
              end
            end else if (g_bc == BURST_W'(1)) begin
              state <= IDLE;
            end else begin
              beat_cnt <= g_bc - BURST_W'(1);
            end
          end else if (rd_acc) begin
            state <= IDLE;
          end else if (!g_read && !g_write && !in_burst) begin
            // granted port withdrew its request before being accepted
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag FIFO pointers, occupancy and orphan flag.
  always_ff @(posedge clk_clk) begin : fifo_ctl_p
    if (reset_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      if (avm.readdatavalid && fifo_empty) begin
        err_orphan <= 1'b1;
      end
    end
  end

  // Tag storage; push and head decrement never target the same slot.
  always_ff @(posedge clk_clk) begin : fifo_mem_p
    if (push) begin
      tag_mem[wr_ptr] <= tag_t'{port: sel1, rem: g_bc};
    end
    if (beat && !pop) begin
      tag_mem[rd_ptr].rem <= head.rem - BURST_W'(1);
    end
  end

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed bench for frame_mem_arbiter: a per-cycle vector table plus
// hand-written sequences for write bursts, tag FIFO full and starvation.
module tb_frame_mem_arbiter;

  localparam int unsigned ADDR_W  = 26;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BURST_W = 4;
  localparam logic [ADDR_W-1:0] A0 = 26'h100;
  localparam logic [ADDR_W-1:0] A1 = 26'h200;
  localparam logic [DATA_W-1:0] WD = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst;
  logic err_orphan;
  int   checks = 0;
  int   errors = 0;

  frame_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) s0_bus ();
  frame_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) s1_bus ();
  frame_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) avm_bus ();

  frame_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .MAX_PEND(4)
  ) dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .s0         (s0_bus),
    .s1         (s1_bus),
    .avm        (avm_bus),
    .err_orphan (err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               rst;
    logic               s0r, s0w;
    logic [BURST_W-1:0] s0bc;
    logic               s1r, s1w;
    logic [BURST_W-1:0] s1bc;
    logic               aw, rdv;
    logic               e_rd, e_wr;
    logic [ADDR_W-1:0]  e_addr;
    logic [BURST_W-1:0] e_bc;
    logic               e_w0, e_w1, e_v0, e_v1, e_err;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    input logic rst_i, s0r, s0w, input logic [BURST_W-1:0] s0bc,
    input logic s1r, s1w, input logic [BURST_W-1:0] s1bc,
    input logic aw, rdv, input logic e_rd, e_wr,
    input logic [ADDR_W-1:0] e_addr, input logic [BURST_W-1:0] e_bc,
    input logic e_w0, e_w1, e_v0, e_v1, e_err);
    vec_t v;
    v.rst = rst_i; v.s0r = s0r; v.s0w = s0w; v.s0bc = s0bc;
    v.s1r = s1r; v.s1w = s1w; v.s1bc = s1bc; v.aw = aw; v.rdv = rdv;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_bc = e_bc;
    v.e_w0 = e_w0; v.e_w1 = e_w1; v.e_v0 = e_v0; v.e_v1 = e_v1; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    s0_bus.read = 1'b0; s0_bus.write = 1'b0; s0_bus.burstcount = '0;
    s1_bus.read = 1'b0; s1_bus.write = 1'b0; s1_bus.burstcount = '0;
    avm_bus.waitrequest = 1'b0; avm_bus.readdatavalid = 1'b0;
  endtask

  int n_acc, n0, n1, s0_before, pend;
  logic rdv_now;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    // Table: state before each row is the state after the previous clock edge.
    //                 rst s0r s0w bc s1r s1w bc aw rdv | rd wr addr bc w0 w1 v0 v1 err
    vt.push_back(mk(1, 0,0,0, 0,0,0, 0,0,  0,0,'0,0,  1,1,0,0,0));
    vt.push_back(mk(0, 1,0,4, 0,0,0, 0,0,  0,0,'0,0,  1,1,0,0,0));
    vt.push_back(mk(0, 1,0,4, 0,0,0, 0,0,  1,0,A0,4,  0,1,0,0,0));
    vt.push_back(mk(0, 0,0,0, 0,0,0, 0,1,  0,0,'0,0,  1,1,1,0,0));
    vt.push_back(mk(0, 0,0,0, 0,0,0, 0,1,  0,0,'0,0,  1,1,1,0,0));
    vt.push_back(mk(0, 0,0,0, 0,0,0, 0,1,  0,0,'0,0,  1,1,1,0,0));
    vt.push_back(mk(0, 0,0,0, 0,0,0, 0,1,  0,0,'0,0,  1,1,1,0,0));
    vt.push_back(mk(0, 0,0,0, 0,0,0, 0,0,  0,0,'0,0,  1,1,0,0,0));
    vt.push_back(mk(0, 1,0,2, 1,0,1, 0,0,  0,0,'0,0,  1,1,0,0,0));
    vt.push_back(mk(0, 1,0,2, 1,0,1, 0,0,  1,0,A0,2,  0,1,0,0,0));
    vt.push_back(mk(0, 0,0,0, 1,0,1, 0,0,  0,0,'0,0,  1,1,0,0,0));
    vt.push_back(mk(0, 0,0,0, 1,0,1, 0,0,  1,0,A1,1,  1,0,0,0,0));
    vt.push_back(mk(0, 0,0,0, 0,0,0, 0,1,  0,0,'0,0,  1,1,1,0,0));
    vt.push_back(mk(0, 0,0,0, 0,0,0, 0,1,  0,0,'0,0,  1,1,1,0,0));
    vt.push_back(mk(0, 0,0,0, 0,0,0, 0,1,  0,0,'0,0,  1,1,0,1,0));
    vt.push_back(mk(0, 0,0,0, 0,0,0, 0,0,  0,0,'0,0,  1,1,0,0,0));
    vt.push_back(mk(0, 0,0,0, 1,0,0, 0,0,  0,0,'0,0,  1,1,0,0,0));
    vt.push_back(mk(0, 0,0,0, 1,0,0, 0,0,  1,0,A1,1,  1,0,0,0,0));
    vt.push_back(mk(0, 0,0,0, 0,0,0, 0,1,  0,0,'0,0,  1,1,0,1,0));
    vt.push_back(mk(0, 0,0,0, 0,0,0, 0,0,  0,0,'0,0,  1,1,0,0,0));
    vt.push_back(mk(0, 1,0,1, 0,0,0, 0,0,  0,0,'0,0,  1,1,0,0,0));
    vt.push_back(mk(0, 1,0,1, 0,0,0, 1,0,  1,0,A0,1,  1,1,0,0,0));
    vt.push_back(mk(0, 1,0,1, 0,0,0, 0,0,  1,0,A0,1,  0,1,0,0,0));
    vt.push_back(mk(0, 0,0,0, 0,0,0, 0,1,  0,0,'0,0,  1,1,1,0,0));
    vt.push_back(mk(0, 0,0,0, 0,0,0, 0,1,  0,0,'0,0,  1,1,0,0,0));
    vt.push_back(mk(0, 0,0,0, 0,0,0, 0,0,  0,0,'0,0,  1,1,0,0,1));
    vt.push_back(mk(1, 0,0,0, 0,0,0, 0,0,  0,0,'0,0,  1,1,0,0,1));
    vt.push_back(mk(0, 0,0,0, 0,0,0, 0,0,  0,0,'0,0,  1,1,0,0,0));

    rst = 1'b1;
    clear_inputs();
    s0_bus.address = A0; s0_bus.writedata = 32'h0;
    s1_bus.address = A1; s1_bus.writedata = WD;
    avm_bus.readdata = 32'h0;
    repeat (2) @(posedge clk);

    foreach (vt[i]) begin
      @(negedge clk);
      rst = vt[i].rst;
      s0_bus.read = vt[i].s0r; s0_bus.write = vt[i].s0w; s0_bus.burstcount = vt[i].s0bc;
      s1_bus.read = vt[i].s1r; s1_bus.write = vt[i].s1w; s1_bus.burstcount = vt[i].s1bc;
      avm_bus.waitrequest = vt[i].aw; avm_bus.readdatavalid = vt[i].rdv;
      avm_bus.readdata = 32'hD000_0000 + 32'(i);
      #1;
      check($sformatf("r%0d avm_read", i), 32'(avm_bus.read), 32'(vt[i].e_rd));
      check($sformatf("r%0d avm_write", i), 32'(avm_bus.write), 32'(vt[i].e_wr));
      check($sformatf("r%0d s0_waitrequest", i), 32'(s0_bus.waitrequest), 32'(vt[i].e_w0));
      check($sformatf("r%0d s1_waitrequest", i), 32'(s1_bus.waitrequest), 32'(vt[i].e_w1));
      check($sformatf("r%0d s0_readdatavalid", i), 32'(s0_bus.readdatavalid), 32'(vt[i].e_v0));
      check($sformatf("r%0d s1_readdatavalid", i), 32'(s1_bus.readdatavalid), 32'(vt[i].e_v1));
      check($sformatf("r%0d err_orphan", i), 32'(err_orphan), 32'(vt[i].e_err));
      if (vt[i].e_rd || vt[i].e_wr) begin
        check($sformatf("r%0d avm_address", i), 32'(avm_bus.address), 32'(vt[i].e_addr));
        check($sformatf("r%0d avm_burstcount", i), 32'(avm_bus.burstcount), 32'(vt[i].e_bc));
      end
      if (vt[i].e_v0) check($sformatf("r%0d s0_readdata", i), s0_bus.readdata, 32'hD000_0000 + 32'(i));
      if (vt[i].e_v1) check($sformatf("r%0d s1_readdata", i), s1_bus.readdata, 32'hD000_0000 + 32'(i));
    end

    // s1 write burst of 4; s0 starts requesting mid-burst and must wait.
    @(negedge clk); clear_inputs(); s1_bus.write = 1'b1; s1_bus.burstcount = 4;
    s1_bus.writedata = WD + 0; #1;
    check("wb req avm_write", 32'(avm_bus.write), 0);
    @(negedge clk); #1;
    check("wb beat0 avm_write", 32'(avm_bus.write), 1);
    check("wb beat0 address", 32'(avm_bus.address), 32'(A1));
    check("wb beat0 burstcount", 32'(avm_bus.burstcount), 4);
    check("wb beat0 writedata", avm_bus.writedata, WD + 0);
    check("wb beat0 s1_waitrequest", 32'(s1_bus.waitrequest), 0);
    @(negedge clk); s1_bus.writedata = WD + 1; s0_bus.read = 1'b1; s0_bus.burstcount = 1; #1;
    check("wb beat1 avm_write", 32'(avm_bus.write), 1);
    check("wb beat1 avm_read", 32'(avm_bus.read), 0);
    check("wb beat1 writedata", avm_bus.writedata, WD + 1);
    check("wb beat1 s0_waitrequest", 32'(s0_bus.waitrequest), 1);
    @(negedge clk); s1_bus.writedata = WD + 2; avm_bus.waitrequest = 1'b1; #1;
    check("wb stall avm_write", 32'(avm_bus.write), 1);
    check("wb stall s1_waitrequest", 32'(s1_bus.waitrequest), 1);
    @(negedge clk); avm_bus.waitrequest = 1'b0; #1;
    check("wb beat2 avm_write", 32'(avm_bus.write), 1);
    check("wb beat2 writedata", avm_bus.writedata, WD + 2);
    @(negedge clk); s1_bus.writedata = WD + 3; #1;
    check("wb beat3 avm_write", 32'(avm_bus.write), 1);
    check("wb beat3 writedata", avm_bus.writedata, WD + 3);
    check("wb beat3 avm_read", 32'(avm_bus.read), 0);
    @(negedge clk); s1_bus.write = 1'b0; #1;
    check("wb done avm_write", 32'(avm_bus.write), 0);
    check("wb done avm_read", 32'(avm_bus.read), 0);
    check("wb done s0_waitrequest", 32'(s0_bus.waitrequest), 1);
    @(negedge clk); #1;
    check("wb then g0 avm_read", 32'(avm_bus.read), 1);
    check("wb then g0 address", 32'(avm_bus.address), 32'(A0));
    check("wb then g0 s0_waitrequest", 32'(s0_bus.waitrequest), 0);
    @(negedge clk); s0_bus.read = 1'b0; avm_bus.readdatavalid = 1'b1; #1;
    check("wb then g0 s0_readdatavalid", 32'(s0_bus.readdatavalid), 1);
    @(negedge clk); avm_bus.readdatavalid = 1'b0; #1;
    check("wb err_orphan", 32'(err_orphan), 0);

    // Five s0 read bursts of 2 with no returns: the fifth waits for the first to drain.
    @(negedge clk); clear_inputs(); s0_bus.read = 1'b1; s0_bus.burstcount = 2;
    n_acc = 0;
    for (int c = 0; c < 20 && n_acc < 4; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (avm_bus.read && !avm_bus.waitrequest) n_acc++;
    end
    check("full accepted reads", 32'(n_acc), 4);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      check($sformatf("full hold%0d avm_read", c), 32'(avm_bus.read), 0);
      check($sformatf("full hold%0d s0_waitrequest", c), 32'(s0_bus.waitrequest), 1);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); avm_bus.readdatavalid = 1'b1; #1;
      check($sformatf("full ret%0d avm_read", c), 32'(avm_bus.read), 0);
      check($sformatf("full ret%0d s0_waitrequest", c), 32'(s0_bus.waitrequest), 1);
      check($sformatf("full ret%0d s0_readdatavalid", c), 32'(s0_bus.readdatavalid), 1);
    end
    @(negedge clk); avm_bus.readdatavalid = 1'b0; #1;
    check("full release avm_read", 32'(avm_bus.read), 1);
    check("full release s0_waitrequest", 32'(s0_bus.waitrequest), 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); s0_bus.read = 1'b0; avm_bus.readdatavalid = 1'b1; #1;
      check($sformatf("full drain%0d s0_readdatavalid", c), 32'(s0_bus.readdatavalid), 1);
      check($sformatf("full drain%0d s1_readdatavalid", c), 32'(s1_bus.readdatavalid), 0);
    end
    @(negedge clk); avm_bus.readdatavalid = 1'b0; #1;
    check("full err_orphan", 32'(err_orphan), 0);

    // Both ports requesting continuously; a small responder returns each beat.
    @(negedge clk); clear_inputs(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    s0_bus.read = 1'b1; s0_bus.burstcount = 1;
    s1_bus.read = 1'b1; s1_bus.burstcount = 1;
    n0 = 0; n1 = 0; s0_before = -1; pend = 0;
    for (int c = 0; c < 80; c++) begin
      if (c != 0) @(negedge clk);
      rdv_now = (pend > 0);
      avm_bus.readdatavalid = rdv_now;
      #1;
      if (avm_bus.read && !avm_bus.waitrequest) begin
        if (avm_bus.address == A1) begin
          if (n1 == 0) s0_before = n0;
          n1++;
        end else begin
          n0++;
        end
        pend++;
      end
      if (rdv_now) pend--;
    end
`ifdef ARB_STARVE_GUARD_EN
    check("starve s0 grants before s1", 32'(s0_before), 8);
    check("starve s1 served", 32'(n1 > 0), 1);
`else
    check("strict s1 grants", 32'(n1), 0);
    check("strict s0 progress", 32'(n0 > 20), 1);
`endif
    @(negedge clk); s0_bus.read = 1'b0; s1_bus.read = 1'b0;
    for (int c = 0; c < 4; c++) begin
      rdv_now = (pend > 0);
      avm_bus.readdatavalid = rdv_now;
      if (rdv_now) pend--;
      @(negedge clk);
    end
    avm_bus.readdatavalid = 1'b0; #1;
    check("starve err_orphan", 32'(err_orphan), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
